// File: rtl/video_frame_meas.sv
// Measures width, height, pixel sum and frame count of a di/de/hs/vs video stream.
// Latency: results and meas_vld_o appear 1 clk after the internal vs-rise cycle (2 edges after vs_i is sampled high).
// Backpressure: none; input is accepted every cycle, output values hold between meas_vld_o pulses.
//
// Ports:
//   clk, rst (sync, active-low)
//   di_i/de_i/hs_i/vs_i : video stream in (hs_i ignored; lines are delimited by de_i)
//   clr_i               : clears stable_o, error flags and the previous-frame reference
//   frame_width_o/frame_height_o/pix_sum_o/frame_cnt_o : last completed frame results
//   meas_vld_o          : one-cycle pulse on every result update
//   err_width_o/err_ovf_o/stable_o : per-frame status
module video_frame_meas #(
    parameter int DATA_WIDTH     = 8,
    parameter int LINE_SIZE_MAX  = 1024,
    parameter int LINE_COUNT_MAX = 1024,
    parameter int CNT_WIDTH      = 11,
    parameter int SUM_WIDTH      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  clr_i,
    output logic [CNT_WIDTH-1:0]  frame_width_o,
    output logic [CNT_WIDTH-1:0]  frame_height_o,
    output logic [SUM_WIDTH-1:0]  pix_sum_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  meas_vld_o,
    output logic                  err_width_o,
    output logic                  err_ovf_o,
    output logic                  stable_o
);

    localparam logic [CNT_WIDTH-1:0] PIX_MAX  = CNT_WIDTH'(LINE_SIZE_MAX);
    localparam logic [CNT_WIDTH-1:0] LINE_MAX = CNT_WIDTH'(LINE_COUNT_MAX);

    typedef enum logic {S_IDLE, S_MEAS} state_t;

    logic hs_unused;
    assign hs_unused = hs_i;

    // Input stage: everything is seen one cycle late so that the vs edge,
    // the pixel on that edge and the closing line are all evaluated together.
    logic [DATA_WIDTH-1:0] s_di_q;
    logic                  s_de_q, s_vs_q, s_clr_q, de_dly_q, vs_dly_q;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, ref_w_q, ref_w_d;
    logic [SUM_WIDTH-1:0]  pix_sum_q, pix_sum_d;
    logic                  werr_q, werr_d, ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  width_q, width_d, height_q, height_d, prev_w_q, prev_w_d, prev_h_q, prev_h_d;
    logic [SUM_WIDTH-1:0]  sum_o_q, sum_o_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  meas_vld_q, meas_vld_d, err_w_q, err_w_d, err_ovf_q, err_ovf_d;
    logic                  stable_q, stable_d, prev_vld_q, prev_vld_d;

    logic                  vs_rise, de_fall, line_close, latch;
    logic [CNT_WIDTH-1:0]  lc_ref, lc_lines;
    logic                  lc_werr, lc_ovf;
    logic [SUM_WIDTH:0]    sum_ext;

    assign vs_rise    = s_vs_q & ~vs_dly_q;
    assign de_fall    = ~s_de_q & de_dly_q;
    // A line still open when vs rises belongs to the frame that is ending.
    assign line_close = (state_q == S_MEAS) && (de_fall || (vs_rise && de_dly_q));
    assign latch      = (state_q == S_MEAS) && vs_rise;
    assign sum_ext    = {1'b0, pix_sum_q} + (SUM_WIDTH+1)'(s_di_q);

    always_comb begin
        // Frame state as it stands once the closing line (if any) is accounted for.
        lc_ref   = ref_w_q;
        lc_werr  = werr_q;
        lc_ovf   = ovf_q;
        lc_lines = line_cnt_q;
        if (line_close) begin
            if (line_cnt_q == '0) begin
                lc_ref = pix_cnt_q;
            end else if (pix_cnt_q != ref_w_q) begin
                lc_werr = 1'b1;
            end
            if (line_cnt_q == LINE_MAX) begin
                lc_ovf = 1'b1;
            end else begin
                lc_lines = line_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = line_close ? '0 : pix_cnt_q;
        pix_sum_d   = pix_sum_q;
        line_cnt_d  = lc_lines;
        ref_w_d     = lc_ref;
        werr_d      = lc_werr;
        ovf_d       = lc_ovf;
        width_d     = width_q;
        height_d    = height_q;
        sum_o_d     = sum_o_q;
        frame_cnt_d = frame_cnt_q;
        meas_vld_d  = 1'b0;
        err_w_d     = err_w_q;
        err_ovf_d   = err_ovf_q;
        stable_d    = stable_q;
        prev_vld_d  = prev_vld_q;
        prev_w_d    = prev_w_q;
        prev_h_d    = prev_h_q;

        // The pixel on the vs-rise cycle is handled below as the new frame's first.
        if ((state_q == S_MEAS) && s_de_q && !vs_rise) begin
            if (pix_cnt_q == PIX_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
            if (sum_ext[SUM_WIDTH]) begin
                pix_sum_d = '1;
                ovf_d     = 1'b1;
            end else begin
                pix_sum_d = sum_ext[SUM_WIDTH-1:0];
            end
        end

        if (latch) begin
            width_d     = lc_ref;
            height_d    = lc_lines;
            sum_o_d     = pix_sum_q;
            err_w_d     = lc_werr;
            err_ovf_d   = lc_ovf;
            frame_cnt_d = frame_cnt_q + 16'd1;
            meas_vld_d  = 1'b1;
            stable_d    = prev_vld_q && (lc_ref == prev_w_q) && (lc_lines == prev_h_q)
                          && !lc_werr && !lc_ovf;
            prev_vld_d  = 1'b1;
            prev_w_d    = lc_ref;
            prev_h_d    = lc_lines;
        end

        if (vs_rise) begin
            state_d    = S_MEAS;
            pix_cnt_d  = s_de_q ? CNT_WIDTH'(1) : '0;
            pix_sum_d  = s_de_q ? SUM_WIDTH'(s_di_q) : '0;
            line_cnt_d = '0;
            ref_w_d    = '0;
            werr_d     = 1'b0;
            ovf_d      = 1'b0;
        end

        // clr beats a coincident latch only for stability; fresh error flags still land.
        if (s_clr_q) begin
            stable_d   = 1'b0;
            prev_vld_d = 1'b0;
            if (!latch) begin
                err_w_d   = 1'b0;
                err_ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_di_q <= '0; s_de_q <= 1'b0; s_vs_q <= 1'b0; s_clr_q <= 1'b0;
            de_dly_q <= 1'b0; vs_dly_q <= 1'b0;
            state_q <= S_IDLE;
            pix_cnt_q <= '0; pix_sum_q <= '0; line_cnt_q <= '0; ref_w_q <= '0;
            werr_q <= 1'b0; ovf_q <= 1'b0;
            width_q <= '0; height_q <= '0; sum_o_q <= '0; frame_cnt_q <= '0;
            meas_vld_q <= 1'b0; err_w_q <= 1'b0; err_ovf_q <= 1'b0; stable_q <= 1'b0;
            prev_vld_q <= 1'b0; prev_w_q <= '0; prev_h_q <= '0;
        end else begin
            s_di_q <= di_i; s_de_q <= de_i; s_vs_q <= vs_i; s_clr_q <= clr_i;
            de_dly_q <= s_de_q; vs_dly_q <= s_vs_q;
            state_q <= state_d;
            pix_cnt_q <= pix_cnt_d; pix_sum_q <= pix_sum_d; line_cnt_q <= line_cnt_d; ref_w_q <= ref_w_d;
            werr_q <= werr_d; ovf_q <= ovf_d;
            width_q <= width_d; height_q <= height_d; sum_o_q <= sum_o_d; frame_cnt_q <= frame_cnt_d;
            meas_vld_q <= meas_vld_d; err_w_q <= err_w_d; err_ovf_q <= err_ovf_d; stable_q <= stable_d;
            prev_vld_q <= prev_vld_d; prev_w_q <= prev_w_d; prev_h_q <= prev_h_d;
        end
    end

    assign frame_width_o  = width_q;
    assign frame_height_o = height_q;
    assign pix_sum_o      = sum_o_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign meas_vld_o     = meas_vld_q;
    assign err_width_o    = err_w_q;
    assign err_ovf_o      = err_ovf_q;
    assign stable_o       = stable_q;

endmodule

// File: tb/tb_video_frame_meas.sv
// Directed bench for video_frame_meas: reset, steady frames, stability, clr,
// width error, overflow, vs during an open line and mid-frame reset.
module tb_video_frame_meas;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  di_i = '0;
    logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, clr_i = 1'b0;
    logic [10:0] frame_width_o, frame_height_o;
    logic [27:0] pix_sum_o;
    logic [15:0] frame_cnt_o;
    logic        meas_vld_o, err_width_o, err_ovf_o, stable_o;

    int n_cmp = 0;
    int n_err = 0;

    video_frame_meas dut (
        .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .clr_i(clr_i),
        .frame_width_o(frame_width_o), .frame_height_o(frame_height_o), .pix_sum_o(pix_sum_o),
        .frame_cnt_o(frame_cnt_o), .meas_vld_o(meas_vld_o), .err_width_o(err_width_o),
        .err_ovf_o(err_ovf_o), .stable_o(stable_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic de, input logic [7:0] d, input logic vs);
        de_i = de; di_i = d; vs_i = vs;
        tick();
    endtask

    task automatic send_line(input int len, input logic [7:0] d);
        repeat (len) drive(1'b1, d, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic send_frame_4x6(input logic [7:0] d);
        repeat (4) send_line(6, d);
    endtask

    // Captures meas_vld_o after each of the three edges following vs_i going high.
    task automatic vs_pulse(output logic [2:0] v);
        drive(1'b0, 8'd0, 1'b1); v[0] = meas_vld_o;
        drive(1'b0, 8'd0, 1'b1); v[1] = meas_vld_o;
        drive(1'b0, 8'd0, 1'b0); v[2] = meas_vld_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({frame_width_o, frame_height_o, pix_sum_o, frame_cnt_o, meas_vld_o, err_width_o, err_ovf_o, stable_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got w=%0d h=%0d s=%0d c=%0d v=%b ew=%b eo=%b st=%b want all 0",
                frame_width_o, frame_height_o, pix_sum_o, frame_cnt_o, meas_vld_o, err_width_o, err_ovf_o, stable_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [2:0] v;
        vs_pulse(v);
        n_cmp++; if (v !== 3'b000) begin n_err++; $display("FAIL basic_first_vs_no_pulse: got %b want 000", v); end
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (v !== 3'b010) begin n_err++; $display("FAIL basic_vld_pulse: got %b want 010", v); end
        n_cmp++; if (frame_width_o !== 11'd6) begin n_err++; $display("FAIL basic_width: got %0d want 6", frame_width_o); end
        n_cmp++; if (frame_height_o !== 11'd4) begin n_err++; $display("FAIL basic_height: got %0d want 4", frame_height_o); end
        n_cmp++; if (pix_sum_o !== 28'd240) begin n_err++; $display("FAIL basic_sum: got %0d want 240", pix_sum_o); end
        n_cmp++; if (frame_cnt_o !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", frame_cnt_o); end
        n_cmp++; if ({err_width_o, err_ovf_o, stable_o} !== 3'b000) begin n_err++; $display("FAIL basic_flags: got %b want 000", {err_width_o, err_ovf_o, stable_o}); end
    endtask

    task automatic test_stable();
        logic [2:0] v;
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (stable_o !== 1'b1) begin n_err++; $display("FAIL stable_2nd: got %b want 1", stable_o); end
        n_cmp++; if (frame_cnt_o !== 16'd2) begin n_err++; $display("FAIL stable_cnt2: got %0d want 2", frame_cnt_o); end
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (stable_o !== 1'b1) begin n_err++; $display("FAIL stable_3rd: got %b want 1", stable_o); end
        n_cmp++; if (frame_cnt_o !== 16'd3) begin n_err++; $display("FAIL stable_cnt3: got %0d want 3", frame_cnt_o); end
    endtask

    task automatic test_clr_stable();
        clr_i = 1'b1; tick(); clr_i = 1'b0; tick(); tick();
        n_cmp++; if (stable_o !== 1'b0) begin n_err++; $display("FAIL clr_stable: got %b want 0", stable_o); end
        n_cmp++; if (frame_width_o !== 11'd6) begin n_err++; $display("FAIL clr_keeps_width: got %0d want 6", frame_width_o); end
    endtask

    task automatic test_width_err();
        logic [2:0] v;
        send_line(6, 8'd10); send_line(6, 8'd10); send_line(5, 8'd10); send_line(6, 8'd10);
        vs_pulse(v);
        n_cmp++; if (err_width_o !== 1'b1) begin n_err++; $display("FAIL werr_flag: got %b want 1", err_width_o); end
        n_cmp++; if (frame_width_o !== 11'd6) begin n_err++; $display("FAIL werr_width: got %0d want 6", frame_width_o); end
        n_cmp++; if (frame_height_o !== 11'd4) begin n_err++; $display("FAIL werr_height: got %0d want 4", frame_height_o); end
        n_cmp++; if (pix_sum_o !== 28'd230) begin n_err++; $display("FAIL werr_sum: got %0d want 230", pix_sum_o); end
        n_cmp++; if (stable_o !== 1'b0) begin n_err++; $display("FAIL werr_stable: got %b want 0", stable_o); end
        n_cmp++; if (frame_cnt_o !== 16'd4) begin n_err++; $display("FAIL werr_cnt: got %0d want 4", frame_cnt_o); end
    endtask

    task automatic test_clr_ref();
        logic [2:0] v;
        clr_i = 1'b1; tick(); clr_i = 1'b0; tick(); tick();
        n_cmp++; if (err_width_o !== 1'b0) begin n_err++; $display("FAIL clr_err_width: got %b want 0", err_width_o); end
        n_cmp++; if (frame_cnt_o !== 16'd4) begin n_err++; $display("FAIL clr_keeps_cnt: got %0d want 4", frame_cnt_o); end
        // Reference was dropped by clr, so the first matching frame cannot be stable.
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (stable_o !== 1'b0) begin n_err++; $display("FAIL clr_first_frame_stable: got %b want 0", stable_o); end
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (stable_o !== 1'b1) begin n_err++; $display("FAIL clr_second_frame_stable: got %b want 1", stable_o); end
        n_cmp++; if (frame_cnt_o !== 16'd6) begin n_err++; $display("FAIL clr_cnt6: got %0d want 6", frame_cnt_o); end
    endtask

    task automatic test_ovf();
        logic [2:0] v;
        send_line(1030, 8'd1);
        vs_pulse(v);
        n_cmp++; if (err_ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", err_ovf_o); end
        n_cmp++; if (frame_width_o !== 11'd1024) begin n_err++; $display("FAIL ovf_width: got %0d want 1024", frame_width_o); end
        n_cmp++; if (frame_height_o !== 11'd1) begin n_err++; $display("FAIL ovf_height: got %0d want 1", frame_height_o); end
        n_cmp++; if (pix_sum_o !== 28'd1030) begin n_err++; $display("FAIL ovf_sum: got %0d want 1030", pix_sum_o); end
        n_cmp++; if (stable_o !== 1'b0) begin n_err++; $display("FAIL ovf_stable: got %b want 0", stable_o); end
    endtask

    task automatic test_vs_during_de();
        logic [2:0] v;
        send_line(6, 8'd5);
        repeat (3) drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd7, 1'b1);
        v[0] = meas_vld_o;
        drive(1'b0, 8'd0, 1'b1);
        v[1] = meas_vld_o;
        n_cmp++; if (frame_height_o !== 11'd2) begin n_err++; $display("FAIL vsde_height: got %0d want 2", frame_height_o); end
        n_cmp++; if (err_width_o !== 1'b1) begin n_err++; $display("FAIL vsde_werr: got %b want 1", err_width_o); end
        n_cmp++; if (frame_width_o !== 11'd6) begin n_err++; $display("FAIL vsde_width: got %0d want 6", frame_width_o); end
        n_cmp++; if (pix_sum_o !== 28'd45) begin n_err++; $display("FAIL vsde_sum: got %0d want 45", pix_sum_o); end
        n_cmp++; if (err_ovf_o !== 1'b0) begin n_err++; $display("FAIL vsde_ovf_cleared: got %b want 0", err_ovf_o); end
        drive(1'b0, 8'd0, 1'b0);
        v[2] = meas_vld_o;
        n_cmp++; if (v !== 3'b010) begin n_err++; $display("FAIL vsde_vld_pulse: got %b want 010", v); end
        drive(1'b0, 8'd0, 1'b0);
        vs_pulse(v);
        n_cmp++; if (pix_sum_o !== 28'd7) begin n_err++; $display("FAIL vsde_next_sum: got %0d want 7", pix_sum_o); end
        n_cmp++; if ({frame_width_o, frame_height_o} !== {11'd1, 11'd1}) begin n_err++; $display("FAIL vsde_next_dims: got %0dx%0d want 1x1", frame_width_o, frame_height_o); end
        n_cmp++; if (err_width_o !== 1'b0) begin n_err++; $display("FAIL vsde_next_werr: got %b want 0", err_width_o); end
        n_cmp++; if (frame_cnt_o !== 16'd9) begin n_err++; $display("FAIL vsde_cnt: got %0d want 9", frame_cnt_o); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] v;
        send_line(6, 8'd10);
        repeat (2) drive(1'b1, 8'd10, 1'b0);
        rst = 1'b0;
        drive(1'b1, 8'd10, 1'b0);
        rst = 1'b1;
        n_cmp++;
        if ({frame_width_o, frame_height_o, pix_sum_o, frame_cnt_o, meas_vld_o, err_width_o, err_ovf_o, stable_o} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got w=%0d h=%0d s=%0d c=%0d v=%b st=%b want all 0",
                frame_width_o, frame_height_o, pix_sum_o, frame_cnt_o, meas_vld_o, stable_o);
        end
        repeat (3) drive(1'b1, 8'd10, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        vs_pulse(v);
        n_cmp++; if (v !== 3'b000) begin n_err++; $display("FAIL midreset_no_pulse: got %b want 000", v); end
        send_frame_4x6(8'd10);
        vs_pulse(v);
        n_cmp++; if (v !== 3'b010) begin n_err++; $display("FAIL midreset_pulse: got %b want 010", v); end
        n_cmp++; if (frame_cnt_o !== 16'd1) begin n_err++; $display("FAIL midreset_cnt: got %0d want 1", frame_cnt_o); end
        n_cmp++; if (pix_sum_o !== 28'd240) begin n_err++; $display("FAIL midreset_sum: got %0d want 240", pix_sum_o); end
        n_cmp++; if ({frame_width_o, frame_height_o} !== {11'd6, 11'd4}) begin n_err++; $display("FAIL midreset_dims: got %0dx%0d want 6x4", frame_width_o, frame_height_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stable();
        test_clr_stable();
        test_width_err();
        test_clr_ref();
        test_ovf();
        test_vs_during_de();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
